param_delay_line: RTL and testbench

//  Parametrised WIDTH x DEPTH register pipeline with per-stage valid bits, stall, synchronous flush,

---
 rtl/param_delay_line.sv | 104 ++++++++++
 tb/tb_param_delay_line.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_delay_line.sv
// WIDTH x DEPTH delay line with per-stage valid, stall, flush, runtime tap and occupancy count.
// Optional collapsed-chain bypass input enabled by defining DELAY_LINE_BYPASS_EN.
module param_delay_line #(
    parameter int               WIDTH = 4,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(7),
    localparam int              TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_flush,
`ifdef DELAY_LINE_BYPASS_EN
    input  logic             i_bypass,
`endif
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_in_valid,
    input  logic [TW-1:0]    i_tap_sel,
    output logic [WIDTH-1:0] o_out,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_tap_data,
    output logic             o_tap_valid,
    output logic             o_tap_err,
    output logic [CW-1:0]    o_fill_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_valid;
    logic [CW-1:0]               r_fill;

    logic                        w_bypass;
    logic [DEPTH-1:0][WIDTH-1:0] w_data_nxt;
    logic [DEPTH-1:0]            w_valid_nxt;
    logic [CW-1:0]               w_fill_nxt;

`ifdef DELAY_LINE_BYPASS_EN
    assign w_bypass = i_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    // Next-state for an enabled, unflushed edge; flush and stall are handled in the register block.
    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_fill_nxt  = r_fill;
        if (w_bypass) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_data_nxt[i]  = i_in;
                w_valid_nxt[i] = i_in_valid;
            end
            w_fill_nxt = i_in_valid ? CW'(DEPTH) : '0;
        end else begin
            w_data_nxt[0]  = i_in;
            w_valid_nxt[0] = i_in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                w_data_nxt[i]  = r_data[i-1];
                w_valid_nxt[i] = r_valid[i-1];
            end
            // Enter and exit in the same edge cancel, so the count cannot exceed DEPTH or wrap.
            w_fill_nxt = r_fill + CW'(i_in_valid) - CW'(r_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= INIT;
            end
            r_valid <= '0;
            r_fill  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= INIT;
            end
            r_valid <= '0;
            r_fill  <= '0;
        end else if (i_en) begin
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    assign o_out       = r_data[DEPTH-1];
    assign o_out_valid = r_valid[DEPTH-1];
    assign o_fill_cnt  = r_fill;

    // Compare-based select keeps out-of-range tap indices from ever addressing the array.
    always_comb begin
        o_tap_data  = '0;
        o_tap_valid = 1'b0;
        o_tap_err   = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_tap_sel == TW'(i)) begin
                o_tap_data  = r_data[i];
                o_tap_valid = r_valid[i];
                o_tap_err   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_delay_line.sv
// Directed self-checking bench for param_delay_line; a DEPTH=2 and a DEPTH=3 instance share stimulus.
module tb_param_delay_line;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       bypass;
    logic [3:0] in_d;
    logic       in_valid;
    logic       tap_sel2;
    logic [1:0] tap_sel3;

    logic [3:0] out2, tap_data2, out3, tap_data3;
    logic       out_valid2, tap_valid2, tap_err2;
    logic       out_valid3, tap_valid3, tap_err3;
    logic [1:0] fill2, fill3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    param_delay_line #(.WIDTH(4), .DEPTH(2), .INIT(4'd7)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_flush(flush),
`ifdef DELAY_LINE_BYPASS_EN
        .i_bypass(bypass),
`endif
        .i_in(in_d), .i_in_valid(in_valid), .i_tap_sel(tap_sel2),
        .o_out(out2), .o_out_valid(out_valid2), .o_tap_data(tap_data2),
        .o_tap_valid(tap_valid2), .o_tap_err(tap_err2), .o_fill_cnt(fill2)
    );

    param_delay_line #(.WIDTH(4), .DEPTH(3), .INIT(4'd7)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_flush(flush),
`ifdef DELAY_LINE_BYPASS_EN
        .i_bypass(bypass),
`endif
        .i_in(in_d), .i_in_valid(in_valid), .i_tap_sel(tap_sel3),
        .o_out(out3), .o_out_valid(out_valid3), .o_tap_data(tap_data3),
        .o_tap_valid(tap_valid3), .o_tap_err(tap_err3), .o_fill_cnt(fill3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic v);
        en = 1'b1; flush = 1'b0; in_d = d; in_valid = v;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; bypass = 1'b0;
        in_d = 4'hC; in_valid = 1'b1; tap_sel2 = 1'b0; tap_sel3 = 2'd0;
        step(); step();
        n_total++; if (out2 !== 4'h7) $display("FAIL reset_out got=%h exp=7", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd0) $display("FAIL reset_fill got=%0d exp=0", fill2); else n_pass++;
        n_total++; if (tap_data2 !== 4'h7) $display("FAIL reset_tap_data got=%h exp=7", tap_data2); else n_pass++;
        n_total++; if (tap_valid2 !== 1'b0) $display("FAIL reset_tap_valid got=%b exp=0", tap_valid2); else n_pass++;
        n_total++; if (out3 !== 4'h7) $display("FAIL reset_out3 got=%h exp=7", out3); else n_pass++;
        en = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        n_total++; if (fill2 !== 2'd0) $display("FAIL reset_release_fill got=%0d exp=0", fill2); else n_pass++;
    endtask

    task automatic test_fill();
        push(4'h3, 1'b1);
        n_total++; if (out2 !== 4'h7) $display("FAIL fill_e1_out got=%h exp=7", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b0) $display("FAIL fill_e1_valid got=%b exp=0", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd1) $display("FAIL fill_e1_cnt got=%0d exp=1", fill2); else n_pass++;
        push(4'h5, 1'b1);
        n_total++; if (out2 !== 4'h3) $display("FAIL fill_e2_out got=%h exp=3", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b1) $display("FAIL fill_e2_valid got=%b exp=1", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd2) $display("FAIL fill_e2_cnt got=%0d exp=2", fill2); else n_pass++;
        push(4'h9, 1'b1);
        n_total++; if (out2 !== 4'h5) $display("FAIL fill_e3_out got=%h exp=5", out2); else n_pass++;
        n_total++; if (fill2 !== 2'd2) $display("FAIL fill_e3_cnt got=%0d exp=2", fill2); else n_pass++;
        tap_sel2 = 1'b0; #1;
        n_total++; if (tap_data2 !== 4'h9) $display("FAIL fill_tap0_data got=%h exp=9", tap_data2); else n_pass++;
        n_total++; if (tap_valid2 !== 1'b1) $display("FAIL fill_tap0_valid got=%b exp=1", tap_valid2); else n_pass++;
        tap_sel2 = 1'b1; #1;
        n_total++; if (tap_data2 !== 4'h5) $display("FAIL fill_tap1_data got=%h exp=5", tap_data2); else n_pass++;
        n_total++; if (tap_err2 !== 1'b0) $display("FAIL fill_tap1_err got=%b exp=0", tap_err2); else n_pass++;
        n_total++; if (fill3 !== 2'd3) $display("FAIL fill_d3_cnt got=%0d exp=3", fill3); else n_pass++;
    endtask

    task automatic test_stall();
        en = 1'b0; in_d = 4'hF; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++; if (out2 !== 4'h5) $display("FAIL stall_out[%0d] got=%h exp=5", k, out2); else n_pass++;
            n_total++; if (out_valid2 !== 1'b1) $display("FAIL stall_valid[%0d] got=%b exp=1", k, out_valid2); else n_pass++;
            n_total++; if (fill2 !== 2'd2) $display("FAIL stall_cnt[%0d] got=%0d exp=2", k, fill2); else n_pass++;
        end
        push(4'h2, 1'b1);
        n_total++; if (out2 !== 4'h9) $display("FAIL stall_resume_out got=%h exp=9", out2); else n_pass++;
        n_total++; if (fill2 !== 2'd2) $display("FAIL stall_resume_cnt got=%0d exp=2", fill2); else n_pass++;
    endtask

    task automatic test_bubbles();
        push(4'h4, 1'b0);
        n_total++; if (out2 !== 4'h2) $display("FAIL bubble_e1_out got=%h exp=2", out2); else n_pass++;
        n_total++; if (fill2 !== 2'd1) $display("FAIL bubble_e1_cnt got=%0d exp=1", fill2); else n_pass++;
        push(4'h6, 1'b0);
        n_total++; if (out2 !== 4'h4) $display("FAIL bubble_e2_out got=%h exp=4", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b0) $display("FAIL bubble_e2_valid got=%b exp=0", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd0) $display("FAIL bubble_e2_cnt got=%0d exp=0", fill2); else n_pass++;
        tap_sel2 = 1'b0; #1;
        n_total++; if (tap_data2 !== 4'h6) $display("FAIL bubble_tap_data got=%h exp=6", tap_data2); else n_pass++;
        n_total++; if (tap_valid2 !== 1'b0) $display("FAIL bubble_tap_valid got=%b exp=0", tap_valid2); else n_pass++;
    endtask

    task automatic test_flush();
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        en = 1'b1; flush = 1'b1; in_d = 4'hA; in_valid = 1'b1;
        step();
        n_total++; if (out2 !== 4'h7) $display("FAIL flush_out got=%h exp=7", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd0) $display("FAIL flush_cnt got=%0d exp=0", fill2); else n_pass++;
        tap_sel2 = 1'b0; #1;
        n_total++; if (tap_data2 !== 4'h7) $display("FAIL flush_tap0 got=%h exp=7", tap_data2); else n_pass++;
        n_total++; if (fill3 !== 2'd0) $display("FAIL flush_cnt3 got=%0d exp=0", fill3); else n_pass++;
        push(4'h0, 1'b0);
        n_total++; if (out2 !== 4'h7) $display("FAIL flush_after1_out got=%h exp=7", out2); else n_pass++;
        push(4'h0, 1'b0);
        n_total++; if (out2 !== 4'h0) $display("FAIL flush_after2_out got=%h exp=0", out2); else n_pass++;
        // flush with en=0 must still clear
        push(4'hB, 1'b1);
        en = 1'b0; flush = 1'b1; in_valid = 1'b1;
        step();
        n_total++; if (fill2 !== 2'd0) $display("FAIL flush_noen_cnt got=%0d exp=0", fill2); else n_pass++;
        tap_sel2 = 1'b0; #1;
        n_total++; if (tap_data2 !== 4'h7) $display("FAIL flush_noen_tap got=%h exp=7", tap_data2); else n_pass++;
        flush = 1'b0;
    endtask

    task automatic test_tap_err();
        push(4'h1, 1'b1);
        push(4'h2, 1'b1);
        push(4'h3, 1'b1);
        n_total++; if (out3 !== 4'h1) $display("FAIL tap_d3_out got=%h exp=1", out3); else n_pass++;
        n_total++; if (fill3 !== 2'd3) $display("FAIL tap_d3_cnt got=%0d exp=3", fill3); else n_pass++;
        n_total++; if (fill2 !== 2'd2) $display("FAIL tap_d2_sat_cnt got=%0d exp=2", fill2); else n_pass++;
        en = 1'b0;
        tap_sel3 = 2'd2; #1;
        n_total++; if (tap_data3 !== 4'h1) $display("FAIL tap2_data got=%h exp=1", tap_data3); else n_pass++;
        n_total++; if (tap_err3 !== 1'b0) $display("FAIL tap2_err got=%b exp=0", tap_err3); else n_pass++;
        n_total++; if (tap_valid3 !== 1'b1) $display("FAIL tap2_valid got=%b exp=1", tap_valid3); else n_pass++;
        tap_sel3 = 2'd1; #1;
        n_total++; if (tap_data3 !== 4'h2) $display("FAIL tap1_data got=%h exp=2", tap_data3); else n_pass++;
        tap_sel3 = 2'd3; #1;
        n_total++; if (tap_err3 !== 1'b1) $display("FAIL tap3_err got=%b exp=1", tap_err3); else n_pass++;
        n_total++; if (tap_data3 !== 4'h0) $display("FAIL tap3_data got=%h exp=0", tap_data3); else n_pass++;
        n_total++; if (tap_valid3 !== 1'b0) $display("FAIL tap3_valid got=%b exp=0", tap_valid3); else n_pass++;
        tap_sel3 = 2'd0;
    endtask

    task automatic test_async_reset();
        push(4'hD, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (out2 !== 4'h7) $display("FAIL areset_out got=%h exp=7", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b0) $display("FAIL areset_valid got=%b exp=0", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd0) $display("FAIL areset_cnt got=%0d exp=0", fill2); else n_pass++;
        n_total++; if (fill3 !== 2'd0) $display("FAIL areset_cnt3 got=%0d exp=0", fill3); else n_pass++;
        en = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

`ifdef DELAY_LINE_BYPASS_EN
    task automatic test_bypass();
        en = 1'b1; flush = 1'b0; bypass = 1'b1; in_d = 4'hA; in_valid = 1'b1;
        step();
        n_total++; if (out2 !== 4'hA) $display("FAIL bypass_out got=%h exp=a", out2); else n_pass++;
        n_total++; if (out_valid2 !== 1'b1) $display("FAIL bypass_valid got=%b exp=1", out_valid2); else n_pass++;
        n_total++; if (fill2 !== 2'd2) $display("FAIL bypass_cnt got=%0d exp=2", fill2); else n_pass++;
        n_total++; if (fill3 !== 2'd3) $display("FAIL bypass_cnt3 got=%0d exp=3", fill3); else n_pass++;
        in_d = 4'h5; in_valid = 1'b0;
        step();
        n_total++; if (fill3 !== 2'd0) $display("FAIL bypass_inv_cnt3 got=%0d exp=0", fill3); else n_pass++;
        n_total++; if (out3 !== 4'h5) $display("FAIL bypass_inv_out3 got=%h exp=5", out3); else n_pass++;
        flush = 1'b1; in_valid = 1'b1;
        step();
        n_total++; if (fill2 !== 2'd0) $display("FAIL bypass_flush_cnt got=%0d exp=0", fill2); else n_pass++;
        flush = 1'b0; bypass = 1'b0; en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_bubbles();
        test_flush();
        test_tap_err();
        test_async_reset();
`ifdef DELAY_LINE_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
